// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: multicycle state encoding, opcodes,
// and the datapath select / ALU encodings used by the controllers.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU operation decoder: maps the controller's ALUOp plus instruction
// function fields onto the ALUControl encoding.
module aludec
    import riscv_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [3:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   ALUControl = ALU_SLT;
                    2'b11:   ALUControl = ALU_SLTU;
                    default: ALUControl = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM over a shared single-port memory
// with ready handshake, bounded wait timeout, illegal-opcode trap and retire pulse.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   FETCH      | read instruction at PC, PC += 4 on ready
//   DECODE     | read registers, ALUOut = OldPC + imm (branch target)
//   MEMADR     | ALUOut = rs1 + imm (load/store address)
//   MEMREAD    | load data from ALUOut address
//   MEMWB      | write loaded data to rd
//   MEMWRITE   | store rs2 to ALUOut address
//   EXECR      | register-register ALU operation
//   EXECI      | register-immediate ALU operation
//   ALUWB      | write ALUOut to rd
//   BRANCH     | compare, load PC from target when taken
//   JAL        | PC = target, ALUOut = OldPC + 4
//   LUI        | ALUOut = 0 + imm
//   TRAP       | illegal opcode or bus timeout; parked until reset
module mc_controller
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT   = 15,
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       LogOut,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       retire,
    output logic       illegal,
    output logic       bus_fault
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_next;
    logic          req, mw, irw, pcw, rw, ret;
    logic          set_illegal, set_fault, timed_out;
    logic [1:0]    ALUOp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            bus_fault <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (set_illegal) illegal   <= 1'b1;
            if (set_fault)   bus_fault <= 1'b1;
        end
    end

    assign timed_out = TIMEOUT_EN && (wait_cnt == WAIT_MAX) && !mem_ready;

    always_comb begin
        state_next  = state;
        req         = 1'b0;
        mw          = 1'b0;
        AdrSrc      = 1'b0;
        irw         = 1'b0;
        pcw         = 1'b0;
        rw          = 1'b0;
        ret         = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ALUOp       = ALUOP_ADD;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        case (state)
            S_FETCH: begin
                req       = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready) begin
                    irw        = 1'b1;
                    pcw        = 1'b1;
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    set_fault  = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
                    default: begin
                        state_next  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req    = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    set_fault  = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                rw         = 1'b1;
                ret        = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                req    = 1'b1;
                mw     = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    ret        = 1'b1;
                    state_next = S_FETCH;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    set_fault  = 1'b1;
                end
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                rw         = 1'b1;
                ret        = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUOp      = ALUOP_BRANCH;
                pcw        = LogOut;
                ret        = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcw        = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            default: state_next = S_TRAP;
        endcase
    end

    // Counter restarts on every state change; saturates so a disabled timeout cannot wrap.
    always_comb begin
        wait_next = wait_cnt;
        if (state_next != state)
            wait_next = '0;
        else if (req && !mem_ready && (wait_cnt != WAIT_MAX))
            wait_next = wait_cnt + CW'(1);
    end

    assign mem_req  = rst_n & req;
    assign MemWrite = rst_n & mw;
    assign IRWrite  = rst_n & irw;
    assign PCWrite  = rst_n & pcw;
    assign RegWrite = rst_n & rw;
    assign retire   = rst_n & ret;
    assign ImmSrc   = imm_src_of(op);

    aludec u_aludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (ALUOp),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-level reference model
// (phase sequences per instruction class) with randomized wait states.
module tb_mc_controller;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       LogOut;
    logic       mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       retire, illegal, bus_fault;

    always #5 clk = ~clk;

    mc_controller #(.MAX_WAIT(15), .TIMEOUT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .LogOut(LogOut), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .retire(retire), .illegal(illegal), .bus_fault(bus_fault)
    );

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_XR, P_XI, P_AWB, P_BR, P_JAL, P_LUI, P_TRAP} phase_t;
    typedef enum {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_LUI} cls_t;
    typedef struct {phase_t ph; bit rdy; bit ill; bit bf;} step_t;

    step_t steps[$];
    int    checks = 0;
    int    errors = 0;
    bit    chk_imm;
    logic [2:0] imm_exp;

    logic [12:0] obs;
    assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire,
                  ResultSrc, ALUSrcA, ALUSrcB};

    // Expected per-phase outputs, straight from the per-state output table.
    function automatic logic [12:0] exp_vec(phase_t ph, bit rdy, bit lo);
        logic req = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ret = 0;
        logic [1:0] rs = 2'b00, a = 2'b00, b = 2'b00;
        case (ph)
            P_F:   begin req = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            P_D:   begin a = 2'b01; b = 2'b01; end
            P_MA:  begin a = 2'b10; b = 2'b01; end
            P_MR:  begin req = 1; adr = 1; end
            P_MWB: begin rs = 2'b01; rw = 1; ret = 1; end
            P_MW:  begin req = 1; mw = 1; adr = 1; ret = rdy; end
            P_XR:  begin a = 2'b10; b = 2'b00; end
            P_XI:  begin a = 2'b10; b = 2'b01; end
            P_AWB: begin rw = 1; ret = 1; end
            P_BR:  begin a = 2'b10; pcw = lo; ret = 1; end
            P_JAL: begin a = 2'b01; b = 2'b10; pcw = 1; end
            P_LUI: begin a = 2'b11; b = 2'b01; end
            default: ;
        endcase
        return {req, mw, adr, irw, pcw, rw, ret, rs, a, b};
    endfunction

    // ALU operation implied by the instruction's ISA meaning in each phase.
    function automatic logic [3:0] exp_alu(phase_t ph, logic [6:0] o, logic [2:0] f3, logic f7);
        if (ph == P_XR || ph == P_XI) begin
            case (f3)
                3'd0: return (ph == P_XR && f7) ? ALU_SUB : ALU_ADD;
                3'd1: return ALU_SLL;
                3'd2: return ALU_SLT;
                3'd3: return ALU_SLTU;
                3'd4: return ALU_XOR;
                3'd5: return f7 ? ALU_SRA : ALU_SRL;
                3'd6: return ALU_OR;
                default: return ALU_AND;
            endcase
        end
        if (ph == P_BR) return ALU_SUB;
        return ALU_ADD;
    endfunction

    function automatic logic [6:0] op_of(cls_t c);
        case (c)
            C_LW:  return 7'b0000011;
            C_SW:  return 7'b0100011;
            C_R:   return 7'b0110011;
            C_I:   return 7'b0010011;
            C_BR:  return 7'b1100011;
            C_JAL: return 7'b1101111;
            default: return 7'b0110111;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(cls_t c);
        case (c)
            C_SW:  return 3'b001;
            C_BR:  return 3'b010;
            C_JAL: return 3'b011;
            C_LUI: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int base_lat(cls_t c);
        case (c)
            C_LW: return 5;
            C_BR: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic push(phase_t ph, bit rdy, bit ill, bit bf);
        step_t s;
        s.ph = ph; s.rdy = rdy; s.ill = ill; s.bf = bf;
        steps.push_back(s);
    endtask

    task automatic build_instr(cls_t c, int fs, int ms);
        repeat (fs) push(P_F, 0, 0, 0);
        push(P_F, 1, 0, 0);
        push(P_D, 1'($urandom_range(0, 1)), 0, 0);
        case (c)
            C_LW: begin
                push(P_MA, 1'($urandom_range(0, 1)), 0, 0);
                repeat (ms) push(P_MR, 0, 0, 0);
                push(P_MR, 1, 0, 0);
                push(P_MWB, 1'($urandom_range(0, 1)), 0, 0);
            end
            C_SW: begin
                push(P_MA, 1'($urandom_range(0, 1)), 0, 0);
                repeat (ms) push(P_MW, 0, 0, 0);
                push(P_MW, 1, 0, 0);
            end
            C_R:   begin push(P_XR, 0, 0, 0);  push(P_AWB, 1, 0, 0); end
            C_I:   begin push(P_XI, 1, 0, 0);  push(P_AWB, 0, 0, 0); end
            C_BR:  push(P_BR, 1'($urandom_range(0, 1)), 0, 0);
            C_JAL: begin push(P_JAL, 0, 0, 0); push(P_AWB, 1, 0, 0); end
            default: begin push(P_LUI, 1, 0, 0); push(P_AWB, 0, 0, 0); end
        endcase
    endtask

    // Drives the queued phases one cycle each and checks every cycle.
    task automatic run_steps(input string tag, output int n, output int ret_at, output int nret);
        logic [12:0] e;
        logic [3:0]  ea;
        n = 0; ret_at = 0; nret = 0;
        while (steps.size() > 0) begin
            step_t s = steps.pop_front();
            @(negedge clk);
            mem_ready = s.rdy;
            #1;
            n++;
            e = exp_vec(s.ph, s.rdy, LogOut);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cyc%0d outputs: got %b exp %b", tag, n, obs, e);
            end
            checks++;
            if ({illegal, bus_fault} !== {s.ill, s.bf}) begin
                errors++;
                $display("FAIL %s cyc%0d flags: got ill=%b bf=%b exp ill=%b bf=%b",
                         tag, n, illegal, bus_fault, s.ill, s.bf);
            end
            ea = exp_alu(s.ph, op, funct3, funct7b5);
            if (s.ph != P_TRAP) begin
                checks++;
                if (ALUControl !== ea) begin
                    errors++;
                    $display("FAIL %s cyc%0d ALUControl: got %h exp %h", tag, n, ALUControl, ea);
                end
            end
            if (chk_imm) begin
                checks++;
                if (ImmSrc !== imm_exp) begin
                    errors++;
                    $display("FAIL %s cyc%0d ImmSrc: got %b exp %b", tag, n, ImmSrc, imm_exp);
                end
            end
            if (retire === 1'b1) begin
                nret++;
                ret_at = n;
            end
        end
    endtask

    task automatic run_instr(input string tag, input cls_t c, input int fs, input int ms);
        int n, ret_at, nret, lat;
        op      = op_of(c);
        chk_imm = (c != C_R);
        imm_exp = imm_of(c);
        build_instr(c, fs, ms);
        run_steps(tag, n, ret_at, nret);
        lat = base_lat(c) + fs + ((c == C_LW || c == C_SW) ? ms : 0);
        checks++;
        if (n !== lat || ret_at !== lat || nret !== 1) begin
            errors++;
            $display("FAIL %s latency: got cycles=%0d retire_at=%0d pulses=%0d exp %0d/%0d/1",
                     tag, n, ret_at, nret, lat, lat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; LogOut = 1'b1;
        op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            checks++;
            if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, retire} !== 6'b0) begin
                errors++;
                $display("FAIL reset_strobes: got %b exp 000000",
                         {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, retire});
            end
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== exp_vec(P_F, 0, 0) || illegal !== 1'b0 || bus_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got %b ill=%b bf=%b exp %b ill=0 bf=0",
                     obs, illegal, bus_fault, exp_vec(P_F, 0, 0));
        end
    endtask

    task automatic test_directed_latency();
        funct3 = 3'b010; funct7b5 = 1'b0;
        run_instr("lw_zero_wait", C_LW, 0, 0);
        run_instr("lw_fetch_stall3", C_LW, 3, 0);
        run_instr("sw_zero_wait", C_SW, 0, 0);
        funct3 = 3'b000; funct7b5 = 1'b1;
        run_instr("sub_rtype", C_R, 0, 0);
        run_instr("jal", C_JAL, 0, 0);
        run_instr("lui", C_LUI, 0, 0);
    endtask

    task automatic test_branch();
        funct3 = 3'b000; funct7b5 = 1'b0;
        LogOut = 1'b1;
        run_instr("beq_taken", C_BR, 0, 0);
        LogOut = 1'b0;
        run_instr("beq_not_taken", C_BR, 0, 0);
    endtask

    task automatic test_random_program();
        for (int i = 0; i < 40; i++) begin
            cls_t c = cls_t'($urandom_range(0, 6));
            int fs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            int ms = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5)) : 0;
            funct7b5 = 1'($urandom_range(0, 1));
            LogOut   = 1'($urandom_range(0, 1));
            case (c)
                C_LW, C_SW: funct3 = 3'b010;
                C_BR:       funct3 = {2'b00, 1'($urandom_range(0, 1))};
                default:    funct3 = 3'($urandom_range(0, 7));
            endcase
            run_instr($sformatf("rand%0d", i), c, fs, ms);
        end
    endtask

    task automatic test_timeout();
        int n, ret_at, nret;
        op = op_of(C_SW); funct3 = 3'b010; chk_imm = 1'b1; imm_exp = 3'b001;
        push(P_F, 1, 0, 0);
        push(P_D, 0, 0, 0);
        push(P_MA, 0, 0, 0);
        repeat (16) push(P_MW, 0, 0, 0);
        repeat (3) push(P_TRAP, 1'($urandom_range(0, 1)), 0, 1);
        run_steps("timeout_sw", n, ret_at, nret);
        checks++;
        if (nret !== 0) begin
            errors++;
            $display("FAIL timeout_retire: got %0d pulses exp 0", nret);
        end
        do_reset();
        checks++;
        if (bus_fault !== 1'b0 || obs !== exp_vec(P_F, 0, 0)) begin
            errors++;
            $display("FAIL timeout_reset_clear: got bf=%b out=%b exp bf=0 out=%b",
                     bus_fault, obs, exp_vec(P_F, 0, 0));
        end
        run_instr("sw_ready_on_16th", C_SW, 0, 15);
        run_instr("lw_ready_on_16th", C_LW, 15, 15);
    endtask

    task automatic test_illegal();
        int n, ret_at, nret;
        op = 7'b0001111; funct3 = 3'b000; chk_imm = 1'b0;
        push(P_F, 1, 0, 0);
        push(P_D, 1, 0, 0);
        repeat (4) push(P_TRAP, 1'($urandom_range(0, 1)), 1, 0);
        run_steps("illegal_op", n, ret_at, nret);
        do_reset();
        checks++;
        if (illegal !== 1'b0 || obs !== exp_vec(P_F, 0, 0)) begin
            errors++;
            $display("FAIL illegal_reset_clear: got ill=%b out=%b exp ill=0 out=%b",
                     illegal, obs, exp_vec(P_F, 0, 0));
        end
        funct3 = 3'b100;
        run_instr("after_illegal_xori", C_I, 0, 0);
    endtask

    task automatic test_reset_mid_sw();
        int n, ret_at, nret;
        op = op_of(C_SW); funct3 = 3'b010; chk_imm = 1'b1; imm_exp = 3'b001;
        push(P_F, 1, 0, 0);
        push(P_D, 0, 0, 0);
        push(P_MA, 0, 0, 0);
        push(P_MW, 0, 0, 0);
        run_steps("sw_before_reset", n, ret_at, nret);
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req, MemWrite, retire} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_sw_abort: got req=%b we=%b ret=%b exp 0 0 0",
                     mem_req, MemWrite, retire);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== exp_vec(P_F, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid_sw_fetch: got %b exp %b", obs, exp_vec(P_F, 0, 0));
        end
        funct3 = 3'b111; funct7b5 = 1'b0;
        run_instr("after_reset_and", C_R, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; LogOut = 1'b0; chk_imm = 1'b0; imm_exp = 3'b000;
        op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
        test_reset();
        test_directed_latency();
        test_branch();
        test_random_program();
        test_timeout();
        test_illegal();
        test_reset_mid_sw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RV32I core: a Moore state machine sequencing fetch, decode, execute, memory and write-back over a shared single-port memory with a variable-latency ready handshake. It keeps the existing `ALUOp`/`ALUControl`, `ImmSrc` and `ResultSrc` encodings of the single-cycle controller. It adds:
- wait states;
- a bounded memory-wait timeout;
- illegal-opcode trapping;
- an instruction-retire pulse.

It sits between the instruction register and the multicycle datapath.

## Interface
- `MAX_WAIT`, 15: max consecutive stalled cycles per memory access before timeout.
- `TIMEOUT_EN`, 1: 0 disables the timeout.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `op  in  7`: IR opcode.
- `funct3  in  3`: IR funct3.
- `funct7b5  in  1`: IR bit 30.
- `LogOut  in  1`: branch condition from ALU.
- `mem_ready  in  1`: memory completes the current access this cycle.
- `mem_req  out  1`: memory access request.
- `MemWrite  out  1`: write strobe, valid with `mem_req`.
- `AdrSrc  out  1`: 0 = PC, 1 = ALUOut.
- `IRWrite  out  1`: load IR and OldPC.
- `PCWrite  out  1`: load PC.
- `RegWrite  out  1`: register-file write.
- `ResultSrc  out  2`: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA  out  2`: 00 PC, 01 OldPC, 10 RD1, 11 zero.
- `ALUSrcB  out  2`: 00 RD2, 01 ImmExt, 10 constant 4.
- `ImmSrc  out  3`: 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUControl  out  4`: ALU operation.
- `retire  out  1`: one-cycle pulse in the final cycle of each instruction.
- `illegal  out  1`: sticky; unsupported opcode trapped.
- `bus_fault  out  1`: sticky; memory timeout trapped.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP.
- **Per-state outputs.** Unlisted outputs are 0; unlisted `ALUOp` is 00.
  - FETCH: `mem_req`, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ResultSrc`=10. `IRWrite` and `PCWrite` only in the cycle `mem_ready`=1.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01.
  - MEMREAD: `mem_req`, `AdrSrc`=1.
  - MEMWB: `ResultSrc`=01, `RegWrite`.
  - MEMWRITE: `mem_req`, `MemWrite`, `AdrSrc`=1.
  - EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10.
  - ALUWB: `ResultSrc`=00, `RegWrite`.
  - BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `PCWrite`=`LogOut`.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=00, `PCWrite`.
  - LUI: `ALUSrcA`=11, `ALUSrcB`=01.
- **Transitions:**
  - FETCH→DECODE on `mem_ready`; otherwise hold.
  - DECODE by `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 0110111 → LUI.
    - anything else → TRAP, set `illegal`.
  - MEMADR → MEMREAD if `op[5]`=0, else MEMWRITE.
  - MEMREAD→MEMWB on `mem_ready`.
  - MEMWRITE→FETCH on `mem_ready`.
  - MEMWB, ALUWB, BRANCH → FETCH.
  - EXECR, EXECI, JAL, LUI → ALUWB.
  - TRAP → TRAP until reset; all strobes 0 while in TRAP.
- **Retire:** `retire`=1 in MEMWB, ALUWB, BRANCH, and in MEMWRITE when `mem_ready`=1.
- **Decoders:**
  - `ImmSrc` is combinational from `op` in every state.
  - `ALUControl` comes from `aludec` fed with `op[5]`, `funct3`, `funct7b5` and the state's `ALUOp`.
- **Wait counter:** width `$clog2(MAX_WAIT+1)`, cleared on entry to FETCH, MEMREAD and MEMWRITE. Increments each cycle `mem_req`=1 and `mem_ready`=0.
- **Timeout:** when `TIMEOUT_EN`, the counter equals `MAX_WAIT`, and `mem_ready`=0 → next state TRAP and set `bus_fault`. `mem_ready`=1 in that same cycle takes priority: the access completes normally.

## Timing
- **Reset:** `rst_n`=0 at a posedge → next state FETCH, counter 0, `illegal`=`bus_fault`=0. While `rst_n`=0, `mem_req`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite` and `retire` are forced 0 combinationally.
- **Mid-operation reset:** reset asserted during MEMWRITE aborts the access. Strobes go 0 in the same cycle; FETCH follows.
- **Latency with zero-wait memory:**
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R/I-type: 4 cycles.
  - branch: 3 cycles.
  - jal: 4 cycles.
  - lui: 4 cycles.
  - Each memory wait cycle adds 1.
- **Handshake:** `mem_req` and `AdrSrc` stay stable while stalled. `MemWrite` is never asserted without `mem_req`.

## Structure
- Shared package `riscv_pkg`: state enum, opcode constants, `ALUOp`/`ImmSrc`/`ResultSrc`/`ALUSrc` encodings.
- Sub-module: the existing `aludec`, instantiated unchanged. Next-state and output logic are written inline.

## Test plan
- **lw, `mem_ready` always 1:** states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `RegWrite`=1 and `retire`=1 only in cycle 5, with `ResultSrc`=01.
- **lw, FETCH ready after 3 stall cycles:** `mem_req`=1 for 4 cycles; `IRWrite`/`PCWrite` pulse only in the 4th; total 8 cycles.
- **beq:** with `LogOut`=1, `PCWrite`=1 in BRANCH with `ALUControl`=sub. With `LogOut`=0, `PCWrite`=0. Both retire after 3 cycles.
- **Timeout, `MAX_WAIT`=15:** `mem_ready` held 0 in MEMWRITE → TRAP on the 16th stalled cycle, `bus_fault`=1, strobes 0 afterwards. Separately, `mem_ready`=1 exactly on the 16th stalled cycle → normal completion.
- **Illegal opcode:** `op`=0001111 → TRAP after DECODE, `illegal`=1 sticky. Reset clears it and returns to FETCH.
- **Reset mid-sw:** `rst_n`=0 while in MEMWRITE → `mem_req`/`MemWrite` 0 in that same cycle, then FETCH.
